hazard_detection_unit: RTL

- Stall/flush controller for the 5-stage MIPS32 pipeline; it works alongside the forwardingUnit.
- Detects hazards that forwarding cannot resolve:
  - load-use into EX;
  - load operand needed by a branch or jr resolved in ID;
  - HI/LO access while the multi-cycle multiply/divide unit is busy.
- Drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID squash.
- Owns the mult/div latency counter and a stall-cycle statistics counter.

---
 rtl/hazard_detection_unit_if.sv | 40 ++++
 rtl/hazard_detection_unit.sv | 84 ++++++++
 2 files changed

// File: rtl/hazard_detection_unit_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX/MEM hazard inputs and stall/flush controls.
// master = pipeline side, slave = hazard_detection_unit.
interface hazard_detection_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       rsID;
    logic [4:0]       rtID;
    logic             useRsID;
    logic             useRtID;
    logic             branchID;
    logic             branchTakenID;
    logic             hiloAccessID;
    logic [4:0]       destRegEX;
    logic             regWriteEX;
    logic             memReadEX;
    logic [4:0]       destRegMEM;
    logic             memReadMEM;
    logic             mdStartEX;
    logic             mdStartDivEX;
    logic             pcWrite;
    logic             ifidWrite;
    logic             idexFlush;
    logic             ifidFlush;
    logic             mdBusy;
    logic [CNT_W-1:0] stallCycles;

    modport master (
        output rsID, rtID, useRsID, useRtID, branchID, branchTakenID, hiloAccessID,
               destRegEX, regWriteEX, memReadEX, destRegMEM, memReadMEM,
               mdStartEX, mdStartDivEX,
        input  pcWrite, ifidWrite, idexFlush, ifidFlush, mdBusy, stallCycles
    );

    modport slave (
        input  rsID, rtID, useRsID, useRtID, branchID, branchTakenID, hiloAccessID,
               destRegEX, regWriteEX, memReadEX, destRegMEM, memReadMEM,
               mdStartEX, mdStartDivEX,
        output pcWrite, ifidWrite, idexFlush, ifidFlush, mdBusy, stallCycles
    );
endinterface

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage MIPS32 pipeline: load-use, branch-on-load
// and HI/LO-busy hazards, plus the mult/div latency counter and stall statistics.
module hazard_detection_unit #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 12,
    parameter int unsigned CNT_W   = 16
) (
    input logic                    Clock,
    input logic                    Reset,
    hazard_detection_unit_if.slave bus
);
    localparam logic [3:0]       MUL_LAT_C = 4'(MUL_LAT);
    localparam logic [3:0]       DIV_LAT_C = 4'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [3:0]       md_count_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             load_use_s;
    logic             branch_load_mem_s;
    logic             md_hazard_s;
    logic             stall_s;

    // Hazard detection; a zero destination never matches anything.
    always_comb begin
        load_use_s        = 1'b0;
        branch_load_mem_s = 1'b0;
        md_hazard_s       = 1'b0;
        if (bus.memReadEX && bus.regWriteEX && (bus.destRegEX != 5'd0)) begin
            load_use_s = (bus.useRsID && (bus.rsID == bus.destRegEX)) ||
                         (bus.useRtID && (bus.rtID == bus.destRegEX));
        end else begin
            load_use_s = 1'b0;
        end
        // Load data from MEM arrives too late for the ID-stage branch compare.
        if (bus.branchID && bus.memReadMEM && (bus.destRegMEM != 5'd0)) begin
            branch_load_mem_s = (bus.rsID == bus.destRegMEM) ||
                                (bus.rtID == bus.destRegMEM);
        end else begin
            branch_load_mem_s = 1'b0;
        end
        if (bus.hiloAccessID) begin
            md_hazard_s = bus.mdStartEX || bus.mdStartDivEX || (md_count_r != 4'd0);
        end else begin
            md_hazard_s = 1'b0;
        end
    end

    assign stall_s = (load_use_s || branch_load_mem_s || md_hazard_s) && !Reset;

    // A taken decision made on stale operands is dropped while stalling.
    assign bus.pcWrite     = !stall_s;
    assign bus.ifidWrite   = !stall_s;
    assign bus.idexFlush   = stall_s;
    assign bus.ifidFlush   = bus.branchTakenID && !stall_s && !Reset;
    assign bus.mdBusy      = (md_count_r != 4'd0) && !Reset;
    assign bus.stallCycles = stall_cnt_r;

    // Mult/div occupancy counter; divide wins on a double start, a new start restarts.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            md_count_r <= 4'd0;
        end else if (bus.mdStartDivEX) begin
            md_count_r <= DIV_LAT_C;
        end else if (bus.mdStartEX) begin
            md_count_r <= MUL_LAT_C;
        end else if (md_count_r != 4'd0) begin
            md_count_r <= md_count_r - 4'd1;
        end else begin
            md_count_r <= md_count_r;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end
endmodule
